// File: rtl/prog_lut_pkg.sv
// Shared constants and types for the programmable lookup table.
package prog_lut_pkg;

  localparam int LUT_ADDR_W = 5;
  localparam int LUT_DATA_W = 8;
  localparam int LUT_BASE   = 60;

  typedef enum logic {
    INIT,
    READY
  } lut_state_e;

endpackage

// File: rtl/lut_init_seq.sv
// Fill sequencer: walks every entry after reset or a restore request,
// producing the default value BASE + index, then reports ready.
module lut_init_seq
  import prog_lut_pkg::*;
#(
  parameter int ADDR_W = LUT_ADDR_W,
  parameter int DATA_W = LUT_DATA_W,
  parameter int BASE   = LUT_BASE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_req,
  output logic              ready,
  output logic              fill_en,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [DATA_W-1:0] fill_data
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int SUM_W = DATA_W + ADDR_W;

  lut_state_e        state;
  logic [ADDR_W-1:0] idx;
  logic [SUM_W-1:0]  sum;

  // Wide add then truncate so the default pattern wraps modulo 2**DATA_W.
  assign sum       = SUM_W'(BASE) + SUM_W'(idx);
  assign fill_data = sum[DATA_W-1:0];
  assign fill_addr = idx;
  assign fill_en   = (state == INIT);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= INIT;
      idx   <= '0;
      ready <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          idx <= idx + 1'b1;
          if (idx == ADDR_W'(DEPTH - 1)) begin
            state <= READY;
            ready <= 1'b1;
          end
        end
        READY: begin
          if (init_req) begin
            state <= INIT;
            idx   <= '0;
            ready <= 1'b0;
          end
        end
        default: begin
          state <= INIT;
          idx   <= '0;
          ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/prog_lut.sv
// Writable constant table with self-initialisation, registered
// write-first reads and a run-time restore of default contents.
module prog_lut
  import prog_lut_pkg::*;
#(
  parameter int ADDR_W = LUT_ADDR_W,
  parameter int DATA_W = LUT_DATA_W,
  parameter int BASE   = LUT_BASE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_req,
  output logic              ready,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic              fill_en;
  logic [ADDR_W-1:0] fill_addr;
  logic [DATA_W-1:0] fill_data;
  logic              user_wr;
  logic              user_rd;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem [DEPTH];

  lut_init_seq #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .BASE   (BASE)
  ) u_init_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_req  (init_req),
    .ready     (ready),
    .fill_en   (fill_en),
    .fill_addr (fill_addr),
    .fill_data (fill_data)
  );

  assign user_wr = ready && wr_en;
  assign user_rd = ready && rd_en;

  // NOTE: every output of this always_comb gets a default first, so no
  // latch is inferred on paths that do not assign it.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    if (fill_en) begin
      mem_we    = 1'b1;
      mem_waddr = fill_addr;
      mem_wdata = fill_data;
    end else if (user_wr) begin
      mem_we = 1'b1;
    end
  end

  // NOTE: storage has no reset; the fill sequence defines its contents,
  // which keeps it mappable to RAM.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= user_rd;
      if (user_rd) begin
        // Write-first bypass for a same-address read in the same cycle.
        rd_data <= (user_wr && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
      end
    end
  end

endmodule

// File: tb/tb_prog_lut.sv
// Self-checking bench for prog_lut: directed steps plus randomized
// traffic against an array model of the table.
module tb_prog_lut;

  localparam int AW    = 5;
  localparam int DW    = 8;
  localparam int DEPTH = 32;
  localparam int BASE  = 60;
  localparam int WBASE = 250;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          init_req;
  logic          ready;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  logic          w_ready;
  logic          w_rd_en;
  logic [AW-1:0] w_rd_addr;
  logic          w_rd_valid;
  logic [DW-1:0] w_rd_data;

  int vectors     = 0;
  int miscompares = 0;
  int model [DEPTH];
  int last_rd;

  always #5 clk = ~clk;

  prog_lut #(.ADDR_W(AW), .DATA_W(DW), .BASE(BASE)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .init_req (init_req),
    .ready    (ready),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );

  prog_lut #(.ADDR_W(AW), .DATA_W(DW), .BASE(WBASE)) dut_w (
    .clk      (clk),
    .rst_n    (rst_n),
    .init_req (1'b0),
    .ready    (w_ready),
    .rd_en    (w_rd_en),
    .rd_addr  (w_rd_addr),
    .rd_valid (w_rd_valid),
    .rd_data  (w_rd_data),
    .wr_en    (1'b0),
    .wr_addr  ('0),
    .wr_data  ('0)
  );

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_defaults();
    for (int i = 0; i < DEPTH; i++) model[i] = (BASE + i) % 256;
  endtask

  // Counts edges until ready rises; an expired budget shows up as a bad count.
  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic read_chk(input string tag, input int a);
    rd_en   = 1'b1;
    rd_addr = AW'(a);
    tick();
    rd_en = 1'b0;
    check({tag, "_valid"}, int'(rd_valid), 1);
    check({tag, "_data"}, int'(rd_data), model[a]);
    last_rd = model[a];
  endtask

  initial begin
    int n;
    rst_n = 1'b0; init_req = 1'b0;
    rd_en = 1'b0; rd_addr = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    w_rd_en = 1'b0; w_rd_addr = '0;

    // Reset state
    tick(); tick();
    check("rst_ready", int'(ready), 0);
    check("rst_rd_valid", int'(rd_valid), 0);
    check("rst_rd_data", int'(rd_data), 0);

    // Init latency, with reads and writes attempted during INIT
    rst_n = 1'b1;
    n = 0;
    while (!ready && n < 200) begin
      wr_en = 1'b1; wr_addr = 5'd3; wr_data = 8'h55;
      rd_en = 1'b1; rd_addr = AW'($urandom_range(0, DEPTH - 1));
      tick();
      n++;
      if (rd_valid !== 1'b0) check("init_rd_valid", int'(rd_valid), 0);
    end
    wr_en = 1'b0; rd_en = 1'b0;
    check("init_latency", n, 32);
    model_defaults();
    tick();
    check("idle_rd_valid", int'(rd_valid), 0);

    // Default contents, including the entry written during INIT
    read_chk("def0", 0);
    check("def0_const", int'(rd_data), 60);
    read_chk("def20", 20);
    check("def20_const", int'(rd_data), 80);
    read_chk("def31", 31);
    check("def31_const", int'(rd_data), 91);
    tick();
    check("rd_valid_clear", int'(rd_valid), 0);
    check("rd_data_hold", int'(rd_data), 91);
    read_chk("init_drop", 3);

    // Write then read
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 8'hAA;
    tick();
    wr_en = 1'b0; model[5] = 'hAA;
    read_chk("wr5", 5);

    // Same-cycle write and read of one address: write-first
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 8'h11;
    rd_en = 1'b1; rd_addr = 5'd7;
    tick();
    wr_en = 1'b0; rd_en = 1'b0; model[7] = 'h11;
    check("wf_valid", int'(rd_valid), 1);
    check("wf_data", int'(rd_data), 'h11);
    last_rd = 'h11;

    // Randomized traffic
    for (int k = 0; k < 60; k++) begin
      int ra, wa, wd, exp_rd;
      bit re, we;
      re = 1'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      ra = $urandom_range(0, DEPTH - 1);
      wa = ($urandom_range(0, 3) == 0) ? ra : $urandom_range(0, DEPTH - 1);
      wd = $urandom_range(0, 255);
      rd_en = re; rd_addr = AW'(ra);
      wr_en = we; wr_addr = AW'(wa); wr_data = DW'(wd);
      exp_rd = (we && wa == ra) ? wd : model[ra];
      tick();
      if (we) model[wa] = wd;
      if (re) last_rd = exp_rd;
      check("rnd_valid", int'(rd_valid), int'(re));
      check("rnd_data", int'(rd_data), last_rd);
    end
    rd_en = 1'b0; wr_en = 1'b0;

    // Restore with a same-cycle read still honoured
    init_req = 1'b1; rd_en = 1'b1; rd_addr = 5'd5;
    tick();
    init_req = 1'b0; rd_en = 1'b0;
    check("restore_ready_low", int'(ready), 0);
    check("restore_rd_valid", int'(rd_valid), 1);
    check("restore_rd_data", int'(rd_data), model[5]);
    wait_ready(n);
    check("restore_latency", n + 1, 33);
    model_defaults();
    read_chk("restore5", 5);
    check("restore5_const", int'(rd_data), 65);

    // Reset in the middle of a fill
    init_req = 1'b1;
    tick();
    init_req = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    check("midinit_not_ready", int'(ready), 0);
    rst_n = 1'b0;
    tick();
    check("midinit_rst_ready", int'(ready), 0);
    rst_n = 1'b1;
    wait_ready(n);
    check("midinit_latency", n, 32);
    for (int a = 0; a < DEPTH; a++) read_chk("midinit_def", a);

    // Wrap on the BASE=250 instance
    check("wrap_ready", int'(w_ready), 1);
    foreach (model[i]) model[i] = (WBASE + i) % 256;
    w_rd_en = 1'b1;
    foreach (model[i]) begin
      if (i == 5 || i == 6 || i == 10) begin
        w_rd_addr = AW'(i);
        tick();
        check("wrap_valid", int'(w_rd_valid), 1);
        check("wrap_data", int'(w_rd_data), model[i]);
      end
    end
    w_rd_en = 1'b0;
    check("wrap6_const", model[6], 0);
    w_rd_addr = 5'd10;
    w_rd_en = 1'b1;
    tick();
    w_rd_en = 1'b0;
    check("wrap10_const", int'(w_rd_data), 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/prog_lut.md
# prog_lut

Parametrised, writable lookup table that replaces the fixed constant ROM in the processor datapath. After reset it self-initialises every entry to `BASE + index` (modulo 2^DATA_W), then serves registered reads and accepts run-time writes from the control path. A re-initialise request restores the default contents without a global reset. It sits beside the decode stage and feeds immediate/target constants to the execute stage.

## Interface

**Parameters**
- `ADDR_W`, default 5: address width; depth is `DEPTH = 2**ADDR_W`.
- `DATA_W`, default 8: entry width.
- `BASE`, default 60: default value of entry 0; entry i defaults to `(BASE + i) mod 2**DATA_W`.

**Ports** (one clock; reset is synchronous and active-low)
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous active-low reset.
- `init_req`  in  1  single-cycle pulse requesting a restore of default contents.
- `ready`  out  1  high when the table is initialised and accepting reads/writes.
- `rd_en`  in  1  read request.
- `rd_addr`  in  ADDR_W  read address.
- `rd_valid`  out  1  rd_data valid this cycle.
- `rd_data`  out  DATA_W  registered read result.
- `wr_en`  in  1  write request.
- `wr_addr`  in  ADDR_W  write address.
- `wr_data`  in  DATA_W  write data.

## Operation

- FSM states: INIT, READY.
- Reset (`rst_n`=0 at an edge):
  - State goes to INIT, fill index 0.
  - `ready`=0, `rd_valid`=0, `rd_data`=0.
  - Storage contents are don't-care until overwritten by INIT.
- INIT:
  - Each edge writes `BASE + idx` (truncated to DATA_W) to entry `idx`, then increments `idx`.
  - On the edge that writes entry DEPTH-1, go to READY.
  - `wr_en`, `rd_en` and `init_req` are ignored (dropped, not queued). `rd_valid` stays 0.
- READY:
  - `wr_en`=1 writes `wr_data` to `wr_addr` at the edge.
  - `rd_en`=1 captures the entry at `rd_addr` into `rd_data` and sets `rd_valid`=1 for one cycle.
  - `rd_en`=0 clears `rd_valid`. `rd_data` holds its last value.
  - `init_req`=1 goes to INIT with idx 0 at the edge and `ready` drops. A `wr_en` or `rd_en` in the same cycle is still honoured.
- Same-address read and write in the same cycle: write-first; `rd_data` returns `wr_data`.
- Arithmetic: `BASE + idx` is computed at DATA_W+ADDR_W bits and truncated to DATA_W, so it wraps silently.
- Reset mid-INIT restarts the fill from idx 0. Reset always has priority over `init_req`.

## Timing

- Init latency: `ready` rises after the DEPTH-th rising edge with `rst_n`=1 following reset. It is registered and glitch-free.
- Read latency: 1 cycle. A request at edge N gives `rd_valid`/`rd_data` visible after edge N.
- Write takes effect at the edge. A read of the same address one cycle later returns the new value.
- Back-to-back reads and writes are allowed every cycle. There is no backpressure; `ready` is the only flow control.
- `init_req` to `ready` high again: DEPTH+1 edges (1 edge to enter INIT, then DEPTH fill edges).

## Structure

- Package `prog_lut_pkg` holds:
  - default parameter constants (`LUT_ADDR_W`, `LUT_DATA_W`, `LUT_BASE`);
  - the state enum `lut_state_e {INIT, READY}`.
- One sub-module: `lut_init_seq`. It contains the INIT/READY FSM and the fill counter, and outputs the fill write enable, address, data and `ready`.
- Storage and the read register live in `prog_lut`. The write mux selects between the `lut_init_seq` fill port and the user write port.

## Test plan

- **Default contents:** reset, wait for `ready`, read addresses 0, 20 and 31 → `rd_data` = 60, 80, 91, each with `rd_valid` one cycle after `rd_en`.
- **Init latency and drop rules:** count edges from `rst_n` release to `ready` → exactly 32. Assert `wr_en`/`rd_en` during INIT → no `rd_valid`, and the contents are unchanged afterwards.
- **Write then read:** write 0xAA to address 5, read 5 the next cycle → 0xAA. A simultaneous write 0x11 and read of address 7 → `rd_data` = 0x11.
- **Restore:** after writes, pulse `init_req` → `ready` low for 32 cycles and high on the 33rd. Address 5 then reads 65.
- **Reset mid-INIT:** assert `rst_n`=0 at fill idx 10 → `ready` rises exactly 32 edges after release, and all entries hold their defaults.
- **Wrap:** BASE=250, DATA_W=8 → entry 5 reads 255, entry 6 reads 0, entry 10 reads 4.
